// File: rtl/display_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | display_ctrl                                                             |
// | Debug-word sequencer for the character LCD: steps an index, waits for   |
// | the datapath to settle, then snapshots an address/data pair.            |
// | Optional feature macro: DISPLAY_AUTOSCAN_EN (auto-scan timer).           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module display_ctrl #(
  parameter int SETTLE    = 2,
  parameter int REFRESH_W = 20,
  parameter int SCAN_W    = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_next,
  input  logic         btn_prev,
  input  logic [1:0]   mode,
  input  logic         auto_en,
  input  logic         freeze,
  input  logic [127:0] dbg_data,
  output logic [7:0]   dbg_addr,
  output logic [7:0]   disp_addr,
  output logic [127:0] disp_data,
  output logic         busy
);

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_NEXT = 2'd1,
    EV_PREV = 2'd2,
    EV_MODE = 2'd3
  } evt_t;

  localparam logic [3:0] c_settle_last = 4'(SETTLE - 1);

  state_t               r_state, w_state_nx;
  evt_t                 r_pend, w_pend_nx, w_evt, w_pend_cmb;
  logic [1:0]           r_pend_mode, w_pend_mode_nx, w_pend_mode_cmb;
  logic [4:0]           r_index, w_index_nx, w_step_index;
  logic [1:0]           r_mode_q, w_mode_nx, w_step_mode;
  logic [3:0]           r_settle, w_settle_nx;
  logic [REFRESH_W-1:0] r_refresh, w_refresh_nx;
  logic                 r_next_q, r_prev_q;
  logic                 w_next_edge, w_prev_edge, w_mode_chg, w_scan_evt;
  logic                 w_capture, w_scan_clr, w_scan_inc;
  logic [7:0]           r_disp_addr;
  logic [127:0]         r_disp_data;

  assign w_next_edge = btn_next & ~r_next_q;
  assign w_prev_edge = btn_prev & ~r_prev_q;
  assign w_mode_chg  = (mode != r_mode_q);

  assign dbg_addr  = {1'b0, r_mode_q, r_index};
  assign disp_addr = r_disp_addr;
  assign disp_data = r_disp_data;
  assign busy      = (r_state != ST_HOLD);

`ifdef DISPLAY_AUTOSCAN_EN
  logic [SCAN_W-1:0] r_scan;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scan <= '0;
    end else if (w_scan_clr) begin
      r_scan <= '0;
    end else if (w_scan_inc) begin
      r_scan <= r_scan + SCAN_W'(1);
    end
  end

  assign w_scan_evt = (r_state == ST_HOLD) && auto_en && !freeze && (&r_scan);
`else
  localparam int c_unused_scan_w = SCAN_W;
  logic w_unused_scan;
  assign w_unused_scan = auto_en ^ w_scan_clr ^ w_scan_inc;
  assign w_scan_evt    = 1'b0;
`endif

  // Mode change beats buttons; simultaneous opposite edges cancel out.
  always_comb begin
    w_evt = EV_NONE;
    if (w_mode_chg) begin
      w_evt = EV_MODE;
    end else if (w_next_edge ^ w_prev_edge) begin
      w_evt = w_next_edge ? EV_NEXT : EV_PREV;
    end else if (w_scan_evt) begin
      w_evt = EV_NEXT;
    end
  end

  // Pending slot merged with this cycle's event; a pending mode change sticks.
  always_comb begin
    w_pend_cmb      = r_pend;
    w_pend_mode_cmb = r_pend_mode;
    if (w_evt == EV_MODE) begin
      w_pend_cmb      = EV_MODE;
      w_pend_mode_cmb = mode;
    end else if ((w_evt != EV_NONE) && (r_pend != EV_MODE)) begin
      w_pend_cmb = w_evt;
    end
  end

  always_comb begin
    w_step_index = r_index;
    w_step_mode  = r_mode_q;
    case (w_pend_cmb)
      EV_NEXT: w_step_index = r_index + 5'd1;
      EV_PREV: w_step_index = r_index - 5'd1;
      EV_MODE: begin
        w_step_index = 5'd0;
        w_step_mode  = w_pend_mode_cmb;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nx     = r_state;
    w_index_nx     = r_index;
    w_mode_nx      = r_mode_q;
    w_pend_nx      = r_pend;
    w_pend_mode_nx = r_pend_mode;
    w_settle_nx    = r_settle;
    w_refresh_nx   = r_refresh;
    w_capture      = 1'b0;
    w_scan_clr     = 1'b0;
    w_scan_inc     = 1'b0;
    case (r_state)
      ST_WAIT: begin
        w_pend_nx      = w_pend_cmb;
        w_pend_mode_nx = w_pend_mode_cmb;
        if (r_settle == c_settle_last) begin
          w_state_nx = ST_CAPTURE;
        end else begin
          w_settle_nx = r_settle + 4'd1;
        end
      end
      ST_CAPTURE: begin
        w_capture = 1'b1;
        if (w_pend_cmb != EV_NONE) begin
          w_index_nx  = w_step_index;
          w_mode_nx   = w_step_mode;
          w_pend_nx   = EV_NONE;
          w_settle_nx = 4'd0;
          w_scan_clr  = 1'b1;
          w_state_nx  = ST_WAIT;
        end else begin
          w_refresh_nx = '0;
          w_state_nx   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_pend_cmb != EV_NONE) begin
          w_index_nx  = w_step_index;
          w_mode_nx   = w_step_mode;
          w_settle_nx = 4'd0;
          w_scan_clr  = 1'b1;
          w_state_nx  = ST_WAIT;
        end else if (!freeze) begin
          // Scan timer is cleared only by steps, so refresh snapshots do not restart it.
          w_scan_inc = 1'b1;
          if (&r_refresh) begin
            w_settle_nx = 4'd0;
            w_state_nx  = ST_WAIT;
          end else begin
            w_refresh_nx = r_refresh + REFRESH_W'(1);
          end
        end
      end
      default: w_state_nx = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_WAIT;
      r_index     <= 5'd0;
      r_mode_q    <= 2'd0;
      r_pend      <= EV_NONE;
      r_pend_mode <= 2'd0;
      r_settle    <= 4'd0;
      r_refresh   <= '0;
      r_next_q    <= 1'b0;
      r_prev_q    <= 1'b0;
      r_disp_addr <= 8'd0;
      r_disp_data <= 128'd0;
    end else begin
      r_state     <= w_state_nx;
      r_index     <= w_index_nx;
      r_mode_q    <= w_mode_nx;
      r_pend      <= w_pend_nx;
      r_pend_mode <= w_pend_mode_nx;
      r_settle    <= w_settle_nx;
      r_refresh   <= w_refresh_nx;
      r_next_q    <= btn_next;
      r_prev_q    <= btn_prev;
      if (w_capture) begin
        r_disp_addr <= dbg_addr;
        r_disp_data <= dbg_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_display_ctrl                                                          |
// | Directed self-checking bench for display_ctrl (SETTLE=2, REFRESH_W=4,   |
// | SCAN_W=6). Honours DISPLAY_AUTOSCAN_EN like the design.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_display_ctrl;

  logic         clk      = 1'b0;
  logic         rst      = 1'b0;
  logic         btn_next = 1'b0;
  logic         btn_prev = 1'b0;
  logic [1:0]   mode     = 2'd0;
  logic         auto_en  = 1'b0;
  logic         freeze   = 1'b1;
  logic [127:0] dbg_data = 128'hA5;
  logic [7:0]   dbg_addr;
  logic [7:0]   disp_addr;
  logic [127:0] disp_data;
  logic         busy;

  int errors = 0;
  int checks = 0;

  display_ctrl #(
    .SETTLE   (2),
    .REFRESH_W(4),
    .SCAN_W   (6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_next (btn_next),
    .btn_prev (btn_prev),
    .mode     (mode),
    .auto_en  (auto_en),
    .freeze   (freeze),
    .dbg_data (dbg_data),
    .dbg_addr (dbg_addr),
    .disp_addr(disp_addr),
    .disp_data(disp_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; mode = 2'd0; dbg_data = 128'hA5;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b expected 1", busy); end
    checks++; if (dbg_addr !== 8'h00) begin errors++; $display("FAIL rst_dbg_addr: got %h expected 00", dbg_addr); end
    checks++; if (disp_addr !== 8'h00) begin errors++; $display("FAIL rst_disp_addr: got %h expected 00", disp_addr); end
    checks++; if (disp_data !== 128'd0) begin errors++; $display("FAIL rst_disp_data: got %h expected 0", disp_data); end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_busy[%0d]: got %b expected 1", i, busy); end
      @(negedge clk);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL first_idle: got %b expected 0", busy); end
    checks++; if (disp_addr !== 8'h00) begin errors++; $display("FAIL first_addr: got %h expected 00", disp_addr); end
    checks++; if (disp_data !== 128'hA5) begin errors++; $display("FAIL first_data: got %h expected a5", disp_data); end
  endtask

  task automatic test_prev_wrap;
    bit ok;
    mode = 2'b01;
    @(negedge clk);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL mode1_timeout: got busy expected idle"); end
    checks++; if (disp_addr !== 8'h20) begin errors++; $display("FAIL mode1_addr: got %h expected 20", disp_addr); end
    btn_prev = 1'b1;
    @(negedge clk);
    btn_prev = 1'b0;
    checks++; if (dbg_addr !== 8'h3F) begin errors++; $display("FAIL prev_dbg_addr: got %h expected 3f", dbg_addr); end
    repeat (2) @(negedge clk);
    checks++; if (disp_addr !== 8'h20) begin errors++; $display("FAIL prev_early: got %h expected 20", disp_addr); end
    @(negedge clk);
    checks++; if (disp_addr !== 8'h3F) begin errors++; $display("FAIL prev_disp_addr: got %h expected 3f", disp_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prev_idle: got %b expected 0", busy); end
  endtask

  task automatic test_both_edges;
    bit bad;
    bad = 1'b0;
    btn_next = 1'b1; btn_prev = 1'b1;
    @(negedge clk);
    btn_next = 1'b0; btn_prev = 1'b0;
    checks++; if (dbg_addr !== 8'h3F) begin errors++; $display("FAIL both_dbg_addr: got %h expected 3f", dbg_addr); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || disp_addr !== 8'h3F) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL both_no_snapshot: got busy=%b addr=%h expected 0/3f", busy, disp_addr); end
  endtask

  task automatic test_back_to_back;
    btn_next = 1'b1;
    @(negedge clk);
    checks++; if (dbg_addr !== 8'h20) begin errors++; $display("FAIL b2b_first_step: got %h expected 20", dbg_addr); end
    btn_next = 1'b0; btn_prev = 1'b1;
    @(negedge clk);
    btn_next = 1'b1; btn_prev = 1'b0;
    @(negedge clk);
    btn_next = 1'b0;
    @(negedge clk);
    checks++; if (disp_addr !== 8'h20) begin errors++; $display("FAIL b2b_mid_disp: got %h expected 20", disp_addr); end
    checks++; if (dbg_addr !== 8'h21) begin errors++; $display("FAIL b2b_pending_dbg: got %h expected 21", dbg_addr); end
    repeat (3) @(negedge clk);
    checks++; if (disp_addr !== 8'h21) begin errors++; $display("FAIL b2b_final_disp: got %h expected 21", disp_addr); end
    repeat (5) @(negedge clk);
    checks++; if (disp_addr !== 8'h21 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_settled: got addr=%h busy=%b expected 21/0", disp_addr, busy);
    end
  endtask

  task automatic test_refresh;
    int first_k, second_k, n_snap;
    bit addr_ok, bad;
    logic [127:0] last;
    first_k = -1; second_k = -1; n_snap = 0; addr_ok = 1'b1; bad = 1'b0;
    last = disp_data;
    freeze = 1'b0; dbg_data = 128'd0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (disp_data !== last) begin
        n_snap++;
        if (n_snap == 1) first_k = k;
        else if (n_snap == 2) second_k = k;
        if (disp_addr !== 8'h21) addr_ok = 1'b0;
        last = disp_data;
      end
      dbg_data = 128'(k);
    end
    checks++; if (first_k != 19) begin errors++; $display("FAIL refresh_first: got cycle %0d expected 19", first_k); end
    checks++; if (second_k != 38) begin errors++; $display("FAIL refresh_second: got cycle %0d expected 38", second_k); end
    checks++; if (n_snap != 2) begin errors++; $display("FAIL refresh_count: got %0d expected 2", n_snap); end
    checks++; if (!addr_ok) begin errors++; $display("FAIL refresh_addr: got changed address expected 21"); end
    checks++; if (disp_data !== 128'd37) begin errors++; $display("FAIL refresh_data: got %h expected 25", disp_data); end
    freeze = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (disp_data !== last || busy !== 1'b0) bad = 1'b1;
      dbg_data = 128'(k + 100);
    end
    checks++; if (bad) begin errors++; $display("FAIL freeze_hold: got snapshot expected none"); end
  endtask

  task automatic test_mid_reset;
    btn_next = 1'b1;
    @(negedge clk);
    checks++; if (dbg_addr !== 8'h22) begin errors++; $display("FAIL mr_step: got %h expected 22", dbg_addr); end
    btn_next = 1'b0; btn_prev = 1'b1;
    @(negedge clk);
    btn_prev = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++; if (dbg_addr !== 8'h00) begin errors++; $display("FAIL mr_dbg_addr: got %h expected 00", dbg_addr); end
    checks++; if (disp_addr !== 8'h00) begin errors++; $display("FAIL mr_disp_addr: got %h expected 00", disp_addr); end
    checks++; if (disp_data !== 128'd0) begin errors++; $display("FAIL mr_disp_data: got %h expected 0", disp_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mr_busy: got %b expected 1", busy); end
    mode = 2'd0; dbg_data = 128'h1234;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || disp_addr !== 8'h00) begin
      errors++; $display("FAIL mr_resnap: got busy=%b addr=%h expected 0/00", busy, disp_addr);
    end
    checks++; if (disp_data !== 128'h1234) begin errors++; $display("FAIL mr_data: got %h expected 1234", disp_data); end
    repeat (5) @(negedge clk);
    checks++; if (disp_addr !== 8'h00 || busy !== 1'b0) begin
      errors++; $display("FAIL mr_pending_dropped: got addr=%h busy=%b expected 00/0", disp_addr, busy);
    end
  endtask

  task automatic test_autoscan;
    bit ok;
    logic [7:0] last;
    freeze = 1'b0; auto_en = 1'b1; mode = 2'b11; btn_next = 1'b1;
    @(negedge clk);
    btn_next = 1'b0;
    checks++; if (dbg_addr !== 8'h60) begin errors++; $display("FAIL mode3_priority: got %h expected 60", dbg_addr); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL mode3_timeout: got busy expected idle"); end
    checks++; if (disp_addr !== 8'h60) begin errors++; $display("FAIL mode3_addr: got %h expected 60", disp_addr); end
    last = disp_addr;
`ifdef DISPLAY_AUTOSCAN_EN
    for (int j = 1; j <= 33; j++) begin
      bit got;
      logic [7:0] exp_addr;
      got = 1'b0;
      exp_addr = 8'(8'h60 + (j % 32));
      for (int c = 0; c < 200 && !got; c++) begin
        @(negedge clk);
        if (disp_addr !== last) got = 1'b1;
      end
      checks++; if (!got || disp_addr !== exp_addr) begin
        errors++; $display("FAIL scan_step[%0d]: got %h expected %h", j, disp_addr, exp_addr);
      end
      last = disp_addr;
    end
`else
    begin
      bit bad;
      int n_data;
      logic [127:0] last_data;
      bad = 1'b0; n_data = 0; last_data = disp_data;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (disp_addr !== 8'h60) bad = 1'b1;
        if (disp_data !== last_data) begin n_data++; last_data = disp_data; end
        dbg_data = 128'(c + 1000);
      end
      checks++; if (bad) begin errors++; $display("FAIL noscan_addr: got %h expected 60", disp_addr); end
      checks++; if (n_data == 0) begin errors++; $display("FAIL noscan_refresh: got 0 snapshots expected >0"); end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_prev_wrap();
    test_both_edges();
    test_back_to_back();
    test_refresh();
    test_mid_reset();
    test_autoscan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
